// File: rtl/zapper_hit_detector.sv
// zapper_hit_detector
// Light-gun shot scoring for the Duck Hunt display loop. The raw trigger
// and photodiode inputs are synchronized, the trigger is debounced, and a
// press starts a two-frame flash sequence (all-black, then white target).
// The photodiode is integrated over active video in each flash frame.
// A shot is a hit only when light is seen in the target frame and not in
// the black frame, so pointing the gun at a lamp scores a miss.
//
// Handshake with the rest of the display loop: there is no valid/ready
// pair here. frame_start and valid are free-running inputs from vga and
// are never stalled. flash_black and flash_target are level requests
// that pattern_gen follows for whole frames. hit and miss are
// single-cycle strobes. All outputs are registered.

module zapper_hit_detector #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DETECT_MIN      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       detect,
    input  logic       frame_start,
    input  logic       valid,
    output logic       flash_black,
    output logic       flash_target,
    output logic       hit,
    output logic       miss,
    output logic       busy,
    output logic [3:0] score
);

    // The debounce counter spans 0 .. DEBOUNCE_CYCLES-1.
    // The level flips on the cycle that completes DEBOUNCE_CYCLES
    // consecutive cycles of disagreement.
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // The detect counter spans 0 .. DETECT_MIN and saturates at the top.
    localparam int DET_W = $clog2(DETECT_MIN + 1);
    localparam logic [DET_W-1:0] DET_FULL = DET_W'(DETECT_MIN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        BLACK    = 3'd2,
        TARGET   = 3'd3,
        RESOLVE  = 3'd4,
        COOLDOWN = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic             trig_s1;
    logic             trig_s2;
    logic             det_s1;
    logic             det_s2;
    logic             deb_level;
    logic             deb_prev;
    logic [DEB_W-1:0] deb_cnt;
    logic [DET_W-1:0] det_cnt;
    logic             lit_black;
    logic             lit_target;
    logic             press;
    logic             det_full;
    logic             target_exit;
    logic             shot_good;

    // Two-flop synchronizers for both asynchronous inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            det_s1  <= 1'b0;
            det_s2  <= 1'b0;
        end else begin
            trig_s1 <= trigger;
            trig_s2 <= trig_s1;
            det_s1  <= detect;
            det_s2  <= det_s1;
        end
    end

    // Debounce: count while the synchronized trigger disagrees with the
    // debounced level, then flip the level once the count completes
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (trig_s2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_level <= trig_s2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev <= 1'b0;
        end else begin
            deb_prev <= deb_level;
        end
    end

    assign press = deb_level & ~deb_prev;

    // Light integration over active video. The counter clears on every
    // frame_start, and the detect sample in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_cnt <= '0;
        end else if (frame_start) begin
            det_cnt <= '0;
        end else if (valid && det_s2 && (det_cnt != DET_FULL)) begin
            det_cnt <= det_cnt + DET_W'(1);
        end
    end

    assign det_full    = (det_cnt == DET_FULL);
    assign target_exit = (state == TARGET) && frame_start;
    // The result is decided at the target-exit edge so that hit, miss and
    // score can be registered and be visible during RESOLVE itself.
    assign shot_good   = det_full && !lit_black;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Presses outside IDLE are ignored. COOLDOWN waits
    // for the trigger to be released, so holding the trigger never re-fires.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (press)       next_state = ARM;
            ARM:      if (frame_start) next_state = BLACK;
            BLACK:    if (frame_start) next_state = TARGET;
            TARGET:   if (frame_start) next_state = RESOLVE;
            RESOLVE:                   next_state = COOLDOWN;
            COOLDOWN: if (!deb_level)  next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // Latch the per-frame light verdicts at each flash-frame exit
    always_ff @(posedge clk) begin
        if (reset) begin
            lit_black  <= 1'b0;
            lit_target <= 1'b0;
        end else begin
            if ((state == BLACK) && frame_start) begin
                lit_black <= det_full;
            end
            if (target_exit) begin
                lit_target <= det_full;
            end
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_black  <= 1'b0;
            flash_target <= 1'b0;
            busy         <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
        end else begin
            flash_black  <= (next_state == BLACK);
            flash_target <= (next_state == TARGET);
            busy         <= (next_state != IDLE);
            hit          <= target_exit && shot_good;
            miss         <= target_exit && !shot_good;
        end
    end

    // Saturating hit counter; the new value appears with the hit pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            score <= 4'd0;
        end else if (target_exit && shot_good && (score != 4'd15)) begin
            score <= score + 4'd1;
        end
    end

    // In RESOLVE the registered strobes must agree with the latched verdicts
    a_resolve_hit : assert property (@(posedge clk) disable iff (reset)
        (state == RESOLVE) |-> (hit == (lit_target && !lit_black)));

    a_resolve_miss : assert property (@(posedge clk) disable iff (reset)
        (state == RESOLVE) |-> (miss == !(lit_target && !lit_black)));

    a_strobe_excl : assert property (@(posedge clk) disable iff (reset)
        !(hit && miss));

endmodule

// File: tb/tb_zapper_hit_detector.sv
// tb_zapper_hit_detector
// Directed bench: a free-running 100-cycle frame generator, a
// photodiode model driven from the flash outputs, shot tasks and a
// saturating score model.

module tb_zapper_hit_detector;

  localparam int DEB   = 4;
  localparam int DMIN  = 3;
  localparam int FRAME = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic       detect;
  logic       frame_start;
  logic       valid;
  logic       flash_black;
  logic       flash_target;
  logic       hit;
  logic       miss;
  logic       busy;
  logic [3:0] score;

  zapper_hit_detector #(
    .DEBOUNCE_CYCLES(DEB),
    .DETECT_MIN(DMIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .detect(detect),
    .frame_start(frame_start),
    .valid(valid),
    .flash_black(flash_black),
    .flash_target(flash_target),
    .hit(hit),
    .miss(miss),
    .busy(busy),
    .score(score)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame generator. pos 0 carries frame_start, and active video is pos 10..89.
  // The photodiode model:
  //   mode 1 is a lamp (always lit).
  //   mode 2 sees the target for 5 cycles.
  //   mode 3 sees the target for 2 cycles, plus light during blanking.
  int pos = 0;
  int det_mode = 0;
  initial begin
    frame_start = 1'b0;
    valid = 1'b0;
    detect = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pos = (pos + 1) % FRAME;
      frame_start = (pos == 0);
      valid = (pos >= 10) && (pos < 90);
      case (det_mode)
        1: detect = 1'b1;
        2: detect = flash_target && (pos >= 20) && (pos < 25);
        3: detect = flash_target && (((pos >= 20) && (pos < 22)) || ((pos >= 92) && (pos < 98)));
        default: detect = 1'b0;
      endcase
    end
  end

  // Output monitor, sampled on the falling edge
  int fb_cycles = 0;
  int ft_cycles = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int busy_rises = 0;
  int fb_rise_pos = -1;
  int ft_rise_pos = -1;
  int res_pos = -1;
  logic [3:0] score_at_hit = 4'd0;
  logic fb_q = 1'b0;
  logic ft_q = 1'b0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    if (flash_black === 1'b1) fb_cycles++;
    if (flash_target === 1'b1) ft_cycles++;
    if ((flash_black === 1'b1) && !fb_q) fb_rise_pos = pos;
    if ((flash_target === 1'b1) && !ft_q) ft_rise_pos = pos;
    if (hit === 1'b1) begin
      hit_cnt++;
      res_pos = pos;
      score_at_hit = score;
    end
    if (miss === 1'b1) begin
      miss_cnt++;
      res_pos = pos;
    end
    if ((busy === 1'b1) && !busy_q) busy_rises++;
    fb_q = (flash_black === 1'b1);
    ft_q = (flash_target === 1'b1);
    busy_q = (busy === 1'b1);
  end

  // driver task: one shot from a released trigger to the return to idle
  task automatic run_shot(input string tag, input int mode, input bit exp_hit,
                          input bit glitch, input int hold_extra);
    int h0;
    int m0;
    int fb0;
    int ft0;
    int b0;
    int n;
    h0 = hit_cnt;
    m0 = miss_cnt;
    fb0 = fb_cycles;
    ft0 = ft_cycles;
    b0 = busy_rises;
    det_mode = mode;
    @(posedge clk);
    #1;
    if (glitch) begin
      trigger = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      trigger = 1'b0;
      @(posedge clk);
      #1;
    end
    trigger = 1'b1;
    n = 0;
    while ((busy !== 1'b1) && (n < 50)) begin
      @(posedge clk);
      n++;
      #1;
    end
    check_eq({tag, " press_latency_in_6_to_8"}, 32'((n >= 6) && (n <= 8)), 32'd1);
    n = 0;
    while ((hit_cnt == h0) && (miss_cnt == m0) && (n < 1000)) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq({tag, " result_seen"}, 32'(n < 1000), 32'd1);
    if (exp_hit) exp_score = (exp_score == 15) ? 15 : exp_score + 1;
    check_eq({tag, " hit_pulses"}, 32'(hit_cnt - h0), exp_hit ? 32'd1 : 32'd0);
    check_eq({tag, " miss_pulses"}, 32'(miss_cnt - m0), exp_hit ? 32'd0 : 32'd1);
    check_eq({tag, " black_cycles"}, 32'(fb_cycles - fb0), 32'(FRAME));
    check_eq({tag, " target_cycles"}, 32'(ft_cycles - ft0), 32'(FRAME));
    check_eq({tag, " black_rise_pos"}, 32'(fb_rise_pos), 32'd1);
    check_eq({tag, " target_rise_pos"}, 32'(ft_rise_pos), 32'd1);
    check_eq({tag, " result_pos"}, 32'(res_pos), 32'd1);
    check_eq({tag, " score"}, 32'(score), 32'(exp_score));
    if (exp_hit) check_eq({tag, " score_with_hit"}, 32'(score_at_hit), 32'(exp_score));
    if (hold_extra > 0) begin
      repeat (hold_extra) @(posedge clk);
      #1;
      check_eq({tag, " held_busy"}, 32'(busy), 32'd1);
      check_eq({tag, " held_no_refire"}, 32'(fb_cycles - fb0), 32'(FRAME));
      check_eq({tag, " held_no_extra_result"}, 32'((hit_cnt - h0) + (miss_cnt - m0)), 32'd1);
    end
    check_eq({tag, " one_sequence"}, 32'(busy_rises - b0), 32'd1);
    trigger = 1'b0;
    n = 0;
    while ((busy !== 1'b0) && (n < 50)) begin
      @(posedge clk);
      n++;
      #1;
    end
    check_eq({tag, " idle_after_release"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int h0;
    int m0;
    reset = 1'b1;
    trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst flash_black", 32'(flash_black), 32'd0);
    check_eq("rst flash_target", 32'(flash_target), 32'd0);
    check_eq("rst hit", 32'(hit), 32'd0);
    check_eq("rst miss", 32'(miss), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst score", 32'(score), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // glitchy pull, clean hit, trigger held across the result
    run_shot("clean_hit", 2, 1'b1, 1'b1, 300);
    // light in the black frame
    run_shot("lamp", 1, 1'b0, 1'b0, 0);
    // too little light in active video
    run_shot("short", 3, 1'b0, 1'b0, 0);
    // climb to saturation: hits 2..15, then a 16th hit at 15
    for (int i = 0; i < 14; i++) run_shot("climb", 2, 1'b1, 1'b0, 0);
    check_eq("score_after_15", 32'(score), 32'd15);
    run_shot("saturate", 2, 1'b1, 1'b0, 0);
    check_eq("score_after_16", 32'(score), 32'd15);

    // reset in the middle of the target frame
    det_mode = 2;
    @(posedge clk);
    #1;
    trigger = 1'b1;
    n = 0;
    while ((flash_target !== 1'b1) && (n < 500)) begin
      @(posedge clk);
      n++;
      #1;
    end
    check_eq("midreset reached_target", 32'(n < 500), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    h0 = hit_cnt;
    m0 = miss_cnt;
    reset = 1'b1;
    trigger = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_score = 0;
    check_eq("midreset flash_black", 32'(flash_black), 32'd0);
    check_eq("midreset flash_target", 32'(flash_target), 32'd0);
    check_eq("midreset busy", 32'(busy), 32'd0);
    check_eq("midreset score", 32'(score), 32'(exp_score));
    repeat (400) @(posedge clk);
    #1;
    check_eq("midreset no_result", 32'((hit_cnt - h0) + (miss_cnt - m0)), 32'd0);
    check_eq("midreset stays_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zapper_hit_detector.md
# zapper_hit_detector

Light-gun side of the Duck Hunt display loop. Conditions the raw trigger and photodiode inputs, answers a trigger pull by requesting a flash sequence from the pattern generator, and scores the shot. The flash sequence is one all-black frame followed by one target-white frame. Detect samples from active video decide the result. Sits beside `vga` and `pattern_gen` in `top`: consumes the `vga` frame-start pulse and `valid`, and drives flash requests and the 4-bit `score`.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles a synchronized trigger level must hold before the debounced level changes.
- `DETECT_MIN`, default 16: detect-high active-video cycles in one frame that count as "light seen".
- `clk`  in  1  pixel clock from `mypll`; only clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `trigger`  in  1  raw gun trigger, asynchronous, 1 = pulled.
- `detect`  in  1  raw photodiode, asynchronous, 1 = light.
- `frame_start`  in  1  one-cycle pulse at the start of each frame (the `vga` screen reset).
- `valid`  in  1  high during active video.
- `flash_black`  out  1  pattern generator draws an all-black frame.
- `flash_target`  out  1  pattern generator draws the white target box on black.
- `hit`  out  1  one-cycle pulse, shot scored.
- `miss`  out  1  one-cycle pulse, shot failed.
- `busy`  out  1  high in any state other than IDLE.
- `score`  out  4  hit count, saturating at 15.

## Operation
- Synchronizers: `trigger` and `detect` each pass through a 2-flop synchronizer before any other use.
- Debounce: a counter runs while the synchronized trigger differs from the debounced level. The counter clears when the two agree. When it reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- A press is a debounced 0→1 edge, one cycle wide.
- Detect counter: counts cycles where `valid` and synchronized detect are both high. It saturates at `DETECT_MIN` and clears on every `frame_start` cycle; the detect sample in that cycle is discarded.
- States:
  - IDLE: on a press, go to ARM.
  - ARM: on `frame_start`, go to BLACK.
  - BLACK: `flash_black`=1. On `frame_start`, latch `lit_black` (counter == `DETECT_MIN`), then go to TARGET.
  - TARGET: `flash_target`=1. On `frame_start`, latch `lit_target` the same way, then go to RESOLVE.
  - RESOLVE: lasts one cycle. If `lit_target` and not `lit_black`, pulse `hit` and increment `score` unless it is 15. Otherwise pulse `miss`. Go to COOLDOWN.
  - COOLDOWN: go to IDLE when the debounced trigger is 0.
- A bright-in-black result counts as a miss. This defeats aiming the gun at a lamp.
- Presses in any state other than IDLE are ignored. Holding the trigger never re-fires.
- `score` changes only in RESOLVE and on reset.

## Timing
- Reset values: all outputs 0, state IDLE, debounced trigger 0, both counters 0, `score` 0.
- Reset asserted mid-sequence takes effect at the next edge. Flash outputs drop the cycle after reset. No `hit` or `miss` is emitted.
- All outputs are registered.
- Flash timing:
  - `flash_black` rises the cycle after the ARM-exit `frame_start`.
  - It falls, and `flash_target` rises, the cycle after the next `frame_start`.
  - `flash_target` falls the cycle after the following `frame_start`.
- `hit`/`miss` asserts one cycle after the TARGET-exit `frame_start`, for exactly one cycle.
- `score` updates in the same cycle as `hit` is asserted.
- Press latency: a trigger edge produces a press after 2 synchronizer cycles plus `DEBOUNCE_CYCLES` + 1 (±1).
- Total latency from press to result: up to 1 frame waiting in ARM, plus 2 frames of flash, plus 1 cycle.
- A press that coincides with `frame_start` enters ARM and waits for the next `frame_start`. A flash frame is therefore always a full frame.
- The detect counter saturates and never wraps.
- `score` at 15 stays 15 on further hits; `hit` still pulses.

## Test plan
- Debounce: `DEBOUNCE_CYCLES`=4. Drive trigger 1 for 3 cycles, 0 for 1, then 1 for 10. Required: exactly one press; `busy` rises 2+4+1 (±1) cycles after the final rise.
- Clean hit: `DETECT_MIN`=3, frame 100 cycles. Detect low in the black frame, high for 5 valid cycles in the target frame. Required: `flash_black` for 100 cycles, then `flash_target` for 100 cycles, then `hit`=1 for one cycle and `score` 0→1.
- Lamp cheat: detect high throughout both frames. Required: `miss` pulse, `score` unchanged.
- Short detect: 2 detect-high cycles in the target frame, plus detect high while `valid`=0. Required: `miss`.
- Hold, re-press and saturation:
  - Hold trigger across and after a result: no second sequence.
  - Release and press 16 hit shots: `score` reads 15 after the 15th and stays 15 after the 16th, with `hit` still pulsing.
- Reset mid-TARGET: assert `reset` for one cycle. Required: both flash outputs, `busy` and `score` are 0 the next cycle; no `hit` or `miss` appears afterward.
